alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Command-side controller for the 4-bit ALU datapath. It accepts operation commands over a valid/ready interface and buffers them in a small FIFO. It issues each command to the ALU by registering its operand and select lines, captures the ALU's result and carry one cycle later, and returns them with the command's tag over a valid/ready response interface. It is the initiator that sits between the command source and the combinational ALU.

## Interface
Parameters:
- DEPTH, 4: command FIFO entries; power of two, ≥2.
- TAG_W, 2: width of the command/response tag.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept a command.
- cmd_op  in  3  ALU select: 000 add, 001 sub, 010 and, 011 or, 100 not-A; others pass through and yield zero.
- cmd_a  in  4  operand A.
- cmd_b  in  4  operand B.
- cmd_tag  in  TAG_W  returned unchanged on the response.
- cmd_chain  in  1  only with ALU_ISSUE_CHAIN_EN; replaces A with the previous result.
- alu_a  out  4  registered operand A to the ALU.
- alu_b  out  4  registered operand B to the ALU.
- alu_sel  out  3  registered select to the ALU.
- alu_result  in  4  ALU result (combinational from alu_a/alu_b/alu_sel).
- alu_carry  in  1  ALU carry_out.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_result  out  4  captured result.
- rsp_carry  out  1  captured carry.
- rsp_tag  out  TAG_W  tag of the command that produced the response.
- busy  out  1  high when the FSM is not in IDLE or the FIFO is non-empty.

## Operation
- Command accept: push on cmd_valid && cmd_ready. cmd_ready = !fifo_full. There is no bypass; every command passes through the FIFO.
- FSM states: IDLE, ISSUE, RESP.
  - IDLE → ISSUE when the FIFO is non-empty. On that edge, pop the head and load alu_a/alu_b/alu_sel and the pending tag.
  - ISSUE → RESP unconditionally. On that edge, capture alu_result/alu_carry into rsp_result/rsp_carry, copy the pending tag to rsp_tag, and set rsp_valid.
  - RESP holds until rsp_valid && rsp_ready.
    - On handshake with the FIFO non-empty: pop and load the next command, go to ISSUE (back-to-back).
    - On handshake with the FIFO empty: go to IDLE.
    - rsp_valid clears on the handshake edge.
- rsp_result, rsp_carry and rsp_tag are stable while rsp_valid=1 and rsp_ready=0. They keep their last value after the handshake.
- alu_a, alu_b and alu_sel change only on a load edge and hold otherwise.
- The block does no arithmetic. Result and carry are exactly what the ALU returns at the end of the ISSUE cycle.
- FIFO pointers have log2(DEPTH)+1 bits. Full and empty are decided by comparing the pointer MSBs and the remaining bits. Pointers wrap modulo 2·DEPTH.
- Simultaneous push and pop in the same cycle are both performed; the count is unchanged. Push while full cannot occur because cmd_ready=0. No pop occurs while empty.
- Reset: all outputs and state are cleared asynchronously. The FIFO is emptied, any in-flight command is dropped and no response is produced.
  - Reset values: cmd_ready=1 after reset release, rsp_valid=0, rsp_result=0, rsp_carry=0, rsp_tag=0, alu_a=0, alu_b=0, alu_sel=000, busy=0.

## Timing
- Command accept edge E0, with FIFO empty and FSM in IDLE:
  - load at E1;
  - capture at E2;
  - rsp_valid high in the cycle after E2.
- Latency is 2 cycles from the accept edge to rsp_valid.
- Throughput with rsp_ready tied high: one response every 2 cycles (ISSUE, then RESP).
- cmd_ready depends only on registered FIFO state. There is no combinational path from rsp_ready to cmd_ready.

## Configuration
- ALU_ISSUE_CHAIN_EN defined:
  - adds the cmd_chain port and stores it in the FIFO;
  - on load, if chain=1, alu_a takes the last captured rsp_result (0 after reset) instead of cmd_a.
- ALU_ISSUE_CHAIN_EN undefined: the cmd_chain port is absent and alu_a is always cmd_a.

## Structure
- Package alu_issue_pkg:
  - opcode constants ALU_OP_ADD/SUB/AND/OR/NOT;
  - FSM state enum (IDLE, ISSUE, RESP);
  - command struct {op, a, b, tag[, chain]}.
- Sub-module alu_issue_fifo: parameterized DEPTH × command-struct synchronous FIFO with full/empty flags.

## Test plan
- Reset, then a single add command A=9, B=8, tag=1 with a reference ALU attached → rsp_valid asserts 2 cycles after accept with result=1, carry=1, tag=1.
- Sub A=3, B=5 → result=14 (4'hE); carry equals the ALU's carry_out sampled at the end of ISSUE. Check that alu_a/alu_b/alu_sel stay stable while RESP is stalled.
- Push DEPTH+1 commands with rsp_ready=0 → cmd_ready drops after the FIFO is full (DEPTH in FIFO plus 1 held). Release rsp_ready → all responses arrive in order with the correct tags and no loss.
- Hold rsp_ready low for 5 cycles during RESP → rsp_result, rsp_carry and rsp_tag do not change. Handshake releases the next command into ISSUE on the same edge.
- Assert rst while in ISSUE with 2 queued commands → all outputs reach reset values immediately and no response is ever produced for the dropped commands.
- With ALU_ISSUE_CHAIN_EN: add 5+3 (result 8), then chained add B=4 → alu_a=8 and result=12. With the macro undefined, the same stream uses cmd_a.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: opcodes, FSM states and command record shared by alu_issue_ctrl and its FIFO.
// Defining ALU_ISSUE_CHAIN_EN adds the chain bit to the command record.
package alu_issue_pkg;
    localparam logic [2:0] ALU_OP_ADD = 3'b000;
    localparam logic [2:0] ALU_OP_SUB = 3'b001;
    localparam logic [2:0] ALU_OP_AND = 3'b010;
    localparam logic [2:0] ALU_OP_OR  = 3'b011;
    localparam logic [2:0] ALU_OP_NOT = 3'b100;
    localparam int CMD_TAG_W = 2;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    typedef struct packed {
        logic [2:0]           op;
        logic [3:0]           a;
        logic [3:0]           b;
        logic [CMD_TAG_W-1:0] tag;
`ifdef ALU_ISSUE_CHAIN_EN
        logic                 chain;
`endif
    } cmd_t;
endpackage

// File: rtl/alu_issue_fifo.sv
// alu_issue_fifo: DEPTH-entry synchronous command FIFO with full/empty flags.
// Pointers carry one extra wrap bit so full and empty are told apart without a counter.
module alu_issue_fifo
    import alu_issue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  cmd_t din,
    input  logic pop,
    output cmd_t dout,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);

    cmd_t          mem_q [DEPTH];
    logic [AW:0]   wp_q, wp_d, rp_q, rp_d;

    always_comb begin
        wp_d = push ? wp_q + 1'b1 : wp_q;
        rp_d = pop ? rp_q + 1'b1 : rp_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q[AW-1:0]] <= din;
    end

    assign dout  = mem_q[rp_q[AW-1:0]];
    assign empty = wp_q == rp_q;
    assign full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: queues ALU commands, issues them on registered operand lines and returns captured results.
// Defining ALU_ISSUE_CHAIN_EN adds cmd_chain, which substitutes the last captured result for operand A.
module alu_issue_ctrl
    import alu_issue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = CMD_TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [3:0]       cmd_a,
    input  logic [3:0]       cmd_b,
    input  logic [TAG_W-1:0] cmd_tag,
`ifdef ALU_ISSUE_CHAIN_EN
    input  logic             cmd_chain,
`endif
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [2:0]       alu_sel,
    input  logic [3:0]       alu_result,
    input  logic             alu_carry,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [3:0]       rsp_result,
    output logic             rsp_carry,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy
);
    cmd_t             push_cmd, head;
    logic             full, empty, load, capture, hs;
    logic [3:0]       load_a;
    state_t           state_q, state_d;
    logic [3:0]       alu_a_q, alu_a_d, alu_b_q, alu_b_d, rsp_result_q, rsp_result_d;
    logic [2:0]       alu_sel_q, alu_sel_d;
    logic [TAG_W-1:0] pend_tag_q, pend_tag_d, rsp_tag_q, rsp_tag_d;
    logic             rsp_carry_q, rsp_carry_d, rsp_valid_q, rsp_valid_d;

    always_comb begin
        push_cmd     = '0;
        push_cmd.op  = cmd_op;
        push_cmd.a   = cmd_a;
        push_cmd.b   = cmd_b;
        push_cmd.tag = CMD_TAG_W'(cmd_tag);
`ifdef ALU_ISSUE_CHAIN_EN
        push_cmd.chain = cmd_chain;
`endif
    end

    alu_issue_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid && !full),
        .din   (push_cmd),
        .pop   (load),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

`ifdef ALU_ISSUE_CHAIN_EN
    assign load_a = head.chain ? rsp_result_q : head.a;
`else
    assign load_a = head.a;
`endif

    assign hs      = rsp_valid_q && rsp_ready;
    assign load    = !empty && (state_q == IDLE || (state_q == RESP && hs));
    assign capture = state_q == ISSUE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_sel_q    <= '0;
            pend_tag_q   <= '0;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_tag_q    <= '0;
            rsp_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_sel_q    <= alu_sel_d;
            pend_tag_q   <= pend_tag_d;
            rsp_result_q <= rsp_result_d;
            rsp_carry_q  <= rsp_carry_d;
            rsp_tag_q    <= rsp_tag_d;
            rsp_valid_q  <= rsp_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = empty ? IDLE : ISSUE;
            ISSUE:   state_d = RESP;
            RESP:    state_d = hs ? (empty ? IDLE : ISSUE) : RESP;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        alu_a_d      = load ? load_a : alu_a_q;
        alu_b_d      = load ? head.b : alu_b_q;
        alu_sel_d    = load ? head.op : alu_sel_q;
        pend_tag_d   = load ? TAG_W'(head.tag) : pend_tag_q;
        rsp_result_d = capture ? alu_result : rsp_result_q;
        rsp_carry_d  = capture ? alu_carry : rsp_carry_q;
        rsp_tag_d    = capture ? pend_tag_q : rsp_tag_q;
        rsp_valid_d  = capture || (rsp_valid_q && !rsp_ready);
    end

    assign cmd_ready  = !full;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_sel    = alu_sel_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_carry  = rsp_carry_q;
    assign rsp_tag    = rsp_tag_q;
    assign busy       = state_q != IDLE || !empty;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed stimulus with a response scoreboard around alu_issue_ctrl and a reference ALU.
// Honours ALU_ISSUE_CHAIN_EN to connect cmd_chain and pick chained expectations.
module tb_alu_issue_ctrl;
    import alu_issue_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready, cmd_chain;
    logic [2:0] cmd_op, alu_sel;
    logic [3:0] cmd_a, cmd_b, alu_a, alu_b, alu_result, rsp_result;
    logic [1:0] cmd_tag, rsp_tag;
    logic       alu_carry, rsp_valid, rsp_ready, rsp_carry, busy;
    logic [6:0] exp_q [$];
    logic [6:0] mon_e;
    int         n_checks = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.DEPTH(4), .TAG_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_tag    (cmd_tag),
`ifdef ALU_ISSUE_CHAIN_EN
        .cmd_chain  (cmd_chain),
`endif
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_result (alu_result),
        .alu_carry  (alu_carry),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_carry  (rsp_carry),
        .rsp_tag    (rsp_tag),
        .busy       (busy)
    );

    // Reference ALU: sub reports the borrow as carry_out.
    always_comb begin
        {alu_carry, alu_result} = 5'b0;
        case (alu_sel)
            ALU_OP_ADD: {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
            ALU_OP_SUB: {alu_carry, alu_result} = {1'b0, alu_a} - {1'b0, alu_b};
            ALU_OP_AND: alu_result = alu_a & alu_b;
            ALU_OP_OR:  alu_result = alu_a | alu_b;
            ALU_OP_NOT: alu_result = ~alu_a;
            default:    {alu_carry, alu_result} = 5'b0;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rsp: got result=%0h carry=%0b tag=%0d with nothing expected", rsp_result, rsp_carry, rsp_tag);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp {result,carry,tag}", {25'b0, rsp_result, rsp_carry, rsp_tag}, {25'b0, mon_e});
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic [1:0] tag, input logic chain);
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag; cmd_chain = chain;
        cmd_valid = 1'b1;
        for (int i = 0; i < 50 && !cmd_ready; i++) tick;
        check("cmd_accept_wait", cmd_ready, 1);
        tick;
        cmd_valid = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [1:0] tag, input logic chain, input logic [3:0] r, input logic c);
        exp_q.push_back({r, c, tag});
        send(op, a, b, tag, chain);
    endtask

    task automatic drain;
        for (int i = 0; i < 80 && exp_q.size() != 0; i++) tick;
        check("drain_empty", exp_q.size(), 0);
        tick;
        tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
        cmd_tag = '0; cmd_chain = 1'b0; rsp_ready = 1'b0;
        #2 rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        tick;
        check("reset cmd_ready", cmd_ready, 1);
        check("reset rsp_valid", rsp_valid, 0);
        check("reset rsp_result", rsp_result, 0);
        check("reset rsp_carry", rsp_carry, 0);
        check("reset rsp_tag", rsp_tag, 0);
        check("reset alu_a", alu_a, 0);
        check("reset alu_b", alu_b, 0);
        check("reset alu_sel", alu_sel, 0);
        check("reset busy", busy, 0);

        // Single add 9+8: load at E1, capture at E2, rsp_valid after E2.
        rsp_ready = 1'b1;
        issue(ALU_OP_ADD, 4'd9, 4'd8, 2'd1, 1'b0, 4'd1, 1'b1);
        check("lat E0 rsp_valid", rsp_valid, 0);
        check("lat E0 busy", busy, 1);
        tick;
        check("lat E1 rsp_valid", rsp_valid, 0);
        check("load alu_a", alu_a, 9);
        check("load alu_b", alu_b, 8);
        check("load alu_sel", alu_sel, ALU_OP_ADD);
        tick;
        check("lat E2 rsp_valid", rsp_valid, 1);
        drain;

        // Sub 3-5 stalled for 5 cycles while an OR waits in the FIFO.
        rsp_ready = 1'b0;
        issue(ALU_OP_SUB, 4'd3, 4'd5, 2'd2, 1'b0, 4'hE, 1'b1);
        tick;
        tick;
        check("sub rsp_valid", rsp_valid, 1);
        issue(ALU_OP_OR, 4'hA, 4'h5, 2'd3, 1'b0, 4'hF, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("stall rsp_valid", rsp_valid, 1);
            check("stall rsp_result", rsp_result, 4'hE);
            check("stall rsp_carry", rsp_carry, 1);
            check("stall rsp_tag", rsp_tag, 2);
            check("stall alu_a", alu_a, 3);
            check("stall alu_b", alu_b, 5);
            check("stall alu_sel", alu_sel, ALU_OP_SUB);
            tick;
        end
        rsp_ready = 1'b1;
        tick;
        check("b2b rsp_valid cleared", rsp_valid, 0);
        check("b2b alu_a", alu_a, 4'hA);
        check("b2b alu_sel", alu_sel, ALU_OP_OR);
        check("b2b keeps rsp_tag", rsp_tag, 2);
        tick;
        check("b2b rsp_valid", rsp_valid, 1);
        drain;

        // DEPTH+1 commands with responses blocked: four queued plus one held.
        rsp_ready = 1'b0;
        issue(ALU_OP_ADD, 4'd7, 4'd7, 2'd0, 1'b0, 4'hE, 1'b0);
        issue(ALU_OP_AND, 4'hC, 4'hA, 2'd1, 1'b0, 4'h8, 1'b0);
        issue(ALU_OP_NOT, 4'h3, 4'h0, 2'd2, 1'b0, 4'hC, 1'b0);
        issue(3'b101,     4'hF, 4'hF, 2'd3, 1'b0, 4'h0, 1'b0);
        issue(ALU_OP_ADD, 4'hF, 4'h1, 2'd0, 1'b0, 4'h0, 1'b1);
        check("full cmd_ready", cmd_ready, 0);
        cmd_op = ALU_OP_OR; cmd_a = 4'h1; cmd_b = 4'h2; cmd_tag = 2'd1; cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            check("full holds cmd_ready", cmd_ready, 0);
        end
        cmd_valid = 1'b0;
        check("full busy", busy, 1);
        rsp_ready = 1'b1;
        drain;
        check("after fill cmd_ready", cmd_ready, 1);

        // Reset while in ISSUE with two commands still queued.
        rsp_ready = 1'b0;
        issue(ALU_OP_ADD, 4'd2, 4'd2, 2'd1, 1'b0, 4'd4, 1'b0);
        send(ALU_OP_ADD, 4'd6, 4'd1, 2'd2, 1'b0);
        send(ALU_OP_SUB, 4'd6, 4'd1, 2'd3, 1'b0);
        send(ALU_OP_OR, 4'd6, 4'd1, 2'd0, 1'b0);
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        check("pre-reset busy", busy, 1);
        check("pre-reset alu_a", alu_a, 6);
        check("pre-reset rsp_valid", rsp_valid, 0);
        rst = 1'b1;
        #1;
        check("async rst rsp_valid", rsp_valid, 0);
        check("async rst rsp_result", rsp_result, 0);
        check("async rst rsp_tag", rsp_tag, 0);
        check("async rst alu_a", alu_a, 0);
        check("async rst alu_b", alu_b, 0);
        check("async rst alu_sel", alu_sel, 0);
        check("async rst busy", busy, 0);
        check("async rst cmd_ready", cmd_ready, 1);
        tick;
        tick;
        rst = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick;
        check("post-reset rsp_valid", rsp_valid, 0);
        check("post-reset busy", busy, 0);
        check("post-reset queue", exp_q.size(), 0);

        // Chained add: 5+3=8, then add B=4 onto it (or onto cmd_a=1 without chaining).
        issue(ALU_OP_ADD, 4'd5, 4'd3, 2'd1, 1'b0, 4'd8, 1'b0);
        drain;
`ifdef ALU_ISSUE_CHAIN_EN
        issue(ALU_OP_ADD, 4'd1, 4'd4, 2'd2, 1'b1, 4'd12, 1'b0);
        tick;
        check("chain alu_a", alu_a, 8);
`else
        issue(ALU_OP_ADD, 4'd1, 4'd4, 2'd2, 1'b1, 4'd5, 1'b0);
        tick;
        check("nochain alu_a", alu_a, 1);
`endif
        drain;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
